// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer for EX, owns HI/LO.
// In: clk, resetn, op_valid_i, op_i, a_i, b_i, flush_i, hi_we_i, lo_we_i, wdata_i.
// Out: stall_o, busy_o, done_o, hi_o, lo_o.
// MULDIV_FAST_MUL_EN: single-cycle combinational MULT/MULTU.
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] am, bm, a_q;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic             neg_q, neg_r, dz_q;

  logic             accept, last, res_we, fast_mul;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   msum, dsh, ddiff;
  logic [WIDTH-1:0] it_hi, it_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] fin_hi, fin_lo;
  logic [WIDTH-1:0] fast_hi, fast_lo;

  // op_i[0]==0 selects the signed variant
  assign a_neg  = ~op_i[0] & a_i[WIDTH-1];
  assign b_neg  = ~op_i[0] & b_i[WIDTH-1];
  assign a_mag  = a_neg ? -a_i : a_i;
  assign b_mag  = b_neg ? -b_i : b_i;
  assign accept = (state == IDLE) & op_valid_i & ~flush_i;
  assign last   = (cnt == CW'(WIDTH - 1));

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fprod;
  assign fast_mul = accept & ~op_i[1];
  always_comb begin
    fprod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
    if (a_neg ^ b_neg) fprod = -fprod;
    fast_hi = fprod[2*WIDTH-1:WIDTH];
    fast_lo = fprod[WIDTH-1:0];
  end
`else
  assign fast_mul = 1'b0;
  assign fast_hi  = '0;
  assign fast_lo  = '0;
`endif

  // one shift-add or restoring-subtract step
  always_comb begin
    msum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? am : '0)};
    dsh   = {acc_hi, acc_lo[WIDTH-1]};
    ddiff = dsh - {1'b0, bm};
    if (!op_q[1]) begin
      {it_hi, it_lo} = {msum, acc_lo[WIDTH-1:1]};
    end else if (!ddiff[WIDTH]) begin
      it_hi = ddiff[WIDTH-1:0];
      it_lo = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      it_hi = dsh[WIDTH-1:0];
      it_lo = {acc_lo[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    prod = {it_hi, it_lo};
    if (neg_q) prod = -prod;
    if (fast_mul) begin
      fin_hi = fast_hi;
      fin_lo = fast_lo;
    end else if (!op_q[1]) begin
      fin_hi = prod[2*WIDTH-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
    end else if (dz_q) begin
      fin_hi = a_q;
      fin_lo = '1;
    end else begin
      fin_hi = neg_r ? -it_hi : it_hi;
      fin_lo = neg_q ? -it_lo : it_lo;
    end
  end

  assign res_we = fast_mul | ((state == BUSY) & last & ~flush_i);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = fast_mul ? DONE : BUSY;
      BUSY:    if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush_i) state_nx = IDLE;
  end

  always_comb begin
    stall_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state)
      IDLE:    stall_o = resetn & op_valid_i & ~flush_i;
      BUSY:    begin
        stall_o = resetn & ~flush_i;
        busy_o  = 1'b1;
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      op_q   <= '0;
      am     <= '0;
      bm     <= '0;
      a_q    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz_q   <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      op_q   <= op_i;
      am     <= a_mag;
      bm     <= b_mag;
      a_q    <= a_i;
      acc_hi <= '0;
      acc_lo <= op_i[1] ? a_mag : b_mag;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      dz_q   <= (b_i == '0);
    end else if (state == BUSY && !flush_i) begin
      cnt    <= cnt + 1'b1;
      acc_hi <= it_hi;
      acc_lo <= it_lo;
    end else if (flush_i) begin
      cnt    <= '0;
    end
  end

  // a completing mul/div is younger than the WB move, so it wins
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_o <= '0;
      lo_o <= '0;
    end else begin
      if (res_we)       hi_o <= fin_hi;
      else if (hi_we_i) hi_o <= wdata_i;
      if (res_we)       lo_o <= fin_lo;
      else if (lo_we_i) lo_o <= wdata_i;
    end
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Multi-cycle sequencer for MULT/MULTU/DIV/DIVU in the EX stage; owns the HI/LO registers.
- Accepts a decoded mul/div op with operands and runs an iterative shift-add multiplier or restoring divider for WIDTH cycles.
- Stalls the pipeline while it runs, then writes HI/LO.
- Also handles MTHI/MTLO writes from WB and cancellation by exception flush.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count = WIDTH; counter width = $clog2(WIDTH).

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- op_valid_i  in  1  EX holds a mul/div instruction
- op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a_i  in  WIDTH  rs operand (multiplicand/dividend)
- b_i  in  WIDTH  rt operand (multiplier/divisor)
- flush_i  in  1  exception flush; cancels any op
- hi_we_i  in  1  MTHI write from WB
- lo_we_i  in  1  MTLO write from WB
- wdata_i  in  WIDTH  MTHI/MTLO data
- stall_o  out  1  hold IF..EX
- busy_o  out  1  state == BUSY
- done_o  out  1  state == DONE (one-cycle pulse)
- hi_o  out  WIDTH  HI register
- lo_o  out  WIDTH  LO register

Behaviour:
- Reset (async, resetn=0): state IDLE, counter 0, hi_o=0, lo_o=0, internal accumulators 0. Outputs stall_o, busy_o and done_o are 0.
- States and transitions:
  - IDLE -> BUSY on edge with op_valid_i=1 && flush_i=0. That edge latches op, |a|, |b|, result sign flags and zero-divisor flag, and clears the counter.
  - BUSY runs one iteration per cycle. Counter counts 0..WIDTH-1. On the edge where counter==WIDTH-1: HI/LO are written with the final result and state -> DONE.
  - DONE -> IDLE unconditionally. op_valid_i is ignored in DONE because the EX instruction is leaving this cycle.
- stall_o = (IDLE && op_valid_i && !flush_i) || BUSY, combinational. stall_o=0 in DONE.
- Stall length: WIDTH+1 cycles (33 for WIDTH=32). The new HI/LO values are visible on hi_o/lo_o in the DONE cycle.
- Signed ops (MULT, DIV): operate on magnitudes. |-2^(WIDTH-1)| = 2^(WIDTH-1) as unsigned.
  - Product negated if operand signs differ.
  - Quotient negated if signs differ. Remainder takes the dividend's sign.
- Multiply: 2*WIDTH-bit product; HI = upper half, LO = lower half.
- Divide: LO = quotient, HI = remainder.
- Divide by zero (any signedness): LO = all ones, HI = a_i as latched. No sign fix, no exception. Still takes the full WIDTH cycles.
- flush_i=1 in any state: next state IDLE, counter cleared, no result write to HI/LO. stall_o is 0 while flush_i=1.
- MTHI/MTLO: hi_we_i / lo_we_i write wdata_i on the edge in any state.
  - If that same edge writes a mul/div result, the mul/div result wins for both HI and LO (it is the younger instruction).
  - If hi_we_i and lo_we_i are both high, both registers are written.
- Reset mid-operation aborts immediately to reset values.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN
- Defined: MULT/MULTU are computed combinationally (single-cycle multiply). IDLE -> DONE directly on the accept edge, HI/LO written on that edge, stall_o high for exactly 1 cycle. DIV/DIVU are unchanged.
- Undefined: MULT/MULTU use the iterative WIDTH-cycle shift-add path, same timing as divide.

Test Plan:
- DIV a=7, b=2 -> stall_o high 33 cycles; in DONE cycle lo_o=0x00000003, hi_o=0x00000001; done_o pulses once.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- DIVU a=0x12345678, b=0 -> lo_o=0xFFFFFFFF, hi_o=0x12345678 after 33 stall cycles.
- MULT 0xFFFFFFFF*2 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE. MULTU same operands -> hi_o=0x00000001, lo_o=0xFFFFFFFE. Stall is 33 cycles without MULDIV_FAST_MUL_EN, 1 cycle with it.
- Preload hi_o=0xAAAA0000 via MTHI; start DIV; assert flush_i in BUSY cycle 10 -> stall_o low that cycle, state IDLE next, hi_o stays 0xAAAA0000, no done_o.
- MTLO wdata=0x5 on the completion edge of MULTU 3*4 -> lo_o=0xC (result wins). Separately, resetn low mid-BUSY -> hi_o=lo_o=0, stall_o=0 immediately.
